// File: rtl/adder_stim_checker.sv
`default_nettype none
// ============================================================================
// Module      : adder_stim_checker
// Description : Built-in self-test engine for a registered ripple adder.
//               Sweeps every {a, b, cin} vector and checks the returned sum and
//               carry. Reports pass/fail, a mismatch count and the first failing
//               vector. Optional macro ADDER_CHK_STOP_ON_FAIL_EN ends the sweep
//               at the first mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_stim_checker #(
    parameter int WIDTH   = 3,
    parameter int LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [WIDTH-1:0]   op_a,
    output logic [WIDTH-1:0]   op_b,
    output logic               op_cin,
    input  logic [WIDTH-1:0]   res_sum,
    input  logic               res_cout,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [7:0]         err_count,
    output logic [2*WIDTH:0]   first_fail
);

    localparam int C_VEC_W = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [C_VEC_W-1:0]   vec_q, vec_d;
    logic [7:0]           err_q, err_d;
    logic [C_VEC_W-1:0]   ff_q, ff_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;

    // Check pipeline: stage LATENCY-1 lines up with the adder result.
    logic [LATENCY-1:0]   pv_q, pv_d;
    logic [C_VEC_W-1:0]   pidx_q [LATENCY];
    logic [C_VEC_W-1:0]   pidx_d [LATENCY];
    logic [WIDTH:0]       pexp_q [LATENCY];
    logic [WIDTH:0]       pexp_d [LATENCY];

    logic [WIDTH-1:0]     w_a;
    logic [WIDTH-1:0]     w_b;
    logic                 w_cin;
    logic [WIDTH:0]       w_expected;
    logic                 w_mismatch;

    assign w_cin      = vec_q[0];
    assign w_b        = vec_q[WIDTH:1];
    assign w_a        = vec_q[2*WIDTH:WIDTH+1];
    assign w_expected = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};
    assign w_mismatch = pv_q[LATENCY-1] &&
                        ({res_cout, res_sum} != pexp_q[LATENCY-1]);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        err_d   = err_q;
        ff_d    = ff_q;

        pv_d[0]   = (state_q == S_RUN);
        pidx_d[0] = vec_q;
        pexp_d[0] = w_expected;
        for (int i = 1; i < LATENCY; i++) begin
            pv_d[i]   = pv_q[i-1];
            pidx_d[i] = pidx_q[i-1];
            pexp_d[i] = pexp_q[i-1];
        end

        if (w_mismatch) begin
            if (err_q != 8'hFF) begin
                err_d = err_q + 8'd1;
            end
            if (err_q == 8'd0) begin
                ff_d = pidx_q[LATENCY-1];
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                vec_d = '0;
                if (start) begin
                    state_d = S_RUN;
                    err_d   = '0;
                    ff_d    = '0;
                end
            end
            S_RUN: begin
                if (vec_q == '1) begin
                    state_d = S_DRAIN;
                end else begin
                    vec_d = vec_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // Leave once the final compare happens on this edge.
                if (pv_d == '0) begin
                    state_d = S_DONE;
                    vec_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                vec_d   = '0;
            end
        endcase

`ifdef ADDER_CHK_STOP_ON_FAIL_EN
        if (w_mismatch) begin
            state_d = S_DONE;
            vec_d   = '0;
            pv_d    = '0;
        end
`endif

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (err_d == 8'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            pv_q    <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pidx_q[i] <= '0;
                pexp_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            pv_q    <= pv_d;
            for (int i = 0; i < LATENCY; i++) begin
                pidx_q[i] <= pidx_d[i];
                pexp_q[i] <= pexp_d[i];
            end
        end
    end

    assign op_cin     = vec_q[0];
    assign op_b       = vec_q[WIDTH:1];
    assign op_a       = vec_q[2*WIDTH:WIDTH+1];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;

endmodule
`default_nettype wire
